// File: rtl/pc_update_if.sv
// rtl/pc_update_if.sv - next-PC request / PC status bundle for pc_update
//
// Purpose: carries the next-PC selection inputs and the registered PC status
// outputs between a pipeline controller (master) and pc_update (slave).
// Signals:
//   alu_result [15:0]  computed next-PC, must narrow cleanly to 6 bits
//   jump_addr  [5:0]   absolute jump target
//   pc_src     [1:0]   00 PC+1, 01 alu_result, 10 jump_addr, 11 hold
//   pc_write           update enable
//   stall              pipeline stall, overrides pc_write
//   trap_clear         leave the trap state
//   PC         [5:0]   current program counter
//   pc_prev    [5:0]   PC before the last accepted update
//   flush              one-cycle pulse after a redirect
//   range_err          high while trapped
interface pc_update_if;
  logic [15:0] alu_result;
  logic [5:0]  jump_addr;
  logic [1:0]  pc_src;
  logic        pc_write;
  logic        stall;
  logic        trap_clear;
  logic [5:0]  PC;
  logic [5:0]  pc_prev;
  logic        flush;
  logic        range_err;

  modport master (
    output alu_result, jump_addr, pc_src, pc_write, stall, trap_clear,
    input  PC, pc_prev, flush, range_err
  );

  modport slave (
    input  alu_result, jump_addr, pc_src, pc_write, stall, trap_clear,
    output PC, pc_prev, flush, range_err
  );
endinterface

// File: rtl/pc_update.sv
// rtl/pc_update.sv - 6-bit program counter update unit with redirect flush and range trap
//
// Purpose: holds the program counter and selects its next value from PC+1,
// a narrowed ALU result or an absolute jump. Redirects raise a one-cycle
// flush; an ALU target that does not fit in 6 signed bits traps the unit
// at TRAP_PC until trap_clear.
// Ports:
//   clock    single clock, all state changes on its rising edge
//   reset_n  synchronous active-low reset
//   bus      pc_update_if slave modport (request inputs, registered status)
module pc_update #(
  parameter logic [5:0] RESET_PC = 6'd0,
  parameter logic [5:0] TRAP_PC  = 6'd63
) (
  input logic         clock,
  input logic         reset_n,
  pc_update_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_TRAP  = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [5:0] pc_q, pc_d;
  logic [5:0] pc_prev_q, pc_prev_d;
  logic       flush_q, flush_d;
  logic       range_err_q, range_err_d;

  logic accept;
  logic narrow_ok;

  // TRAP ignores every update; RUN and FLUSH behave identically here.
  assign accept = (state_q != ST_TRAP) && bus.pc_write && !bus.stall &&
                  (bus.pc_src != 2'b11);

  // The ALU target fits in 6 bits only if its upper bits are a pure
  // sign extension of bit 5.
  assign narrow_ok = (bus.alu_result[15:6] == {10{bus.alu_result[5]}});

  always_comb begin
    pc_d        = pc_q;
    pc_prev_d   = pc_prev_q;
    flush_d     = 1'b0;
    range_err_d = 1'b0;
    // FLUSH is a single cycle: without a new redirect it falls back to RUN.
    state_d     = ST_RUN;

    if (state_q == ST_TRAP) begin
      if (bus.trap_clear) begin
        state_d = ST_RUN;
      end else begin
        state_d     = ST_TRAP;
        range_err_d = 1'b1;
      end
    end else if (accept) begin
      pc_prev_d = pc_q;
      unique case (bus.pc_src)
        2'b00: begin
          pc_d = pc_q + 6'd1;
        end
        2'b01: begin
          if (narrow_ok) begin
            pc_d    = bus.alu_result[5:0];
            state_d = ST_FLUSH;
            flush_d = 1'b1;
          end else begin
            pc_d        = TRAP_PC;
            state_d     = ST_TRAP;
            range_err_d = 1'b1;
          end
        end
        2'b10: begin
          pc_d    = bus.jump_addr;
          state_d = ST_FLUSH;
          flush_d = 1'b1;
        end
        default: begin
          pc_d = pc_q;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= ST_RUN;
      pc_q        <= RESET_PC;
      pc_prev_q   <= RESET_PC;
      flush_q     <= 1'b0;
      range_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pc_prev_q   <= pc_prev_d;
      flush_q     <= flush_d;
      range_err_q <= range_err_d;
    end
  end

  assign bus.PC        = pc_q;
  assign bus.pc_prev   = pc_prev_q;
  assign bus.flush     = flush_q;
  assign bus.range_err = range_err_q;

endmodule

// File: tb/tb_pc_update.sv
// tb/tb_pc_update.sv - scoreboard testbench for pc_update
module tb_pc_update;

  logic clk;
  logic rst_n;
  int   cyc;

  int n_cmp;
  int n_bad;

  pc_update_if bus ();

  pc_update #(
    .RESET_PC (6'd0),
    .TRAP_PC  (6'd63)
  ) dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus.slave)
  );

  typedef struct {
    int         due;
    logic [5:0] pc;
    logic [5:0] prev;
    logic       fl;
    logic       er;
    string      name;
  } exp_t;

  exp_t exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares every output sample that has an expectation due.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      n_cmp = n_cmp + 1;
      if (bus.PC !== e.pc || bus.pc_prev !== e.prev ||
          bus.flush !== e.fl || bus.range_err !== e.er) begin
        n_bad = n_bad + 1;
        $display("FAIL %s: got PC=%0d pc_prev=%0d flush=%b range_err=%b, want PC=%0d pc_prev=%0d flush=%b range_err=%b",
                 e.name, bus.PC, bus.pc_prev, bus.flush, bus.range_err,
                 e.pc, e.prev, e.fl, e.er);
      end
    end
  end

  task automatic step(input string name, input logic rst, input logic [1:0] src,
                      input logic [15:0] alu, input logic [5:0] jmp,
                      input logic wr, input logic stl, input logic clr,
                      input logic [5:0] e_pc, input logic [5:0] e_prev,
                      input logic e_fl, input logic e_er);
    exp_t e;
    rst_n              = rst;
    bus.pc_src         = src;
    bus.alu_result     = alu;
    bus.jump_addr      = jmp;
    bus.pc_write       = wr;
    bus.stall          = stl;
    bus.trap_clear     = clr;
    e.due  = cyc + 1;
    e.pc   = e_pc;
    e.prev = e_prev;
    e.fl   = e_fl;
    e.er   = e_er;
    e.name = name;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n          = 1'b0;
    bus.pc_src     = 2'b00;
    bus.alu_result = 16'h0000;
    bus.jump_addr  = 6'd0;
    bus.pc_write   = 1'b0;
    bus.stall      = 1'b0;
    bus.trap_clear = 1'b0;
    @(posedge clk);
    #1;

    // Reset state
    step("reset0", 0, 2'b00, 16'h0, 6'd0, 1, 0, 1, 6'd0, 6'd0, 0, 0);
    step("reset1", 0, 2'b10, 16'h0, 6'd9, 1, 0, 0, 6'd0, 6'd0, 0, 0);

    // Increment across the 63 -> 0 wrap
    for (int i = 0; i < 70; i++)
      step($sformatf("inc%0d", i), 1, 2'b00, 16'h0, 6'd0, 1, 0, 0,
           6'((i + 1) % 64), 6'(i % 64), 0, 0);

    // Legal negative ALU target from PC=5
    step("rst_a", 0, 2'b00, 16'h0, 6'd0, 0, 0, 0, 6'd0, 6'd0, 0, 0);
    for (int i = 0; i < 5; i++)
      step($sformatf("to5a_%0d", i), 1, 2'b00, 16'h0, 6'd0, 1, 0, 0,
           6'(i + 1), 6'(i), 0, 0);
    step("alu_fffe",   1, 2'b01, 16'hFFFE, 6'd0, 1, 0, 0, 6'd62, 6'd5, 1, 0);
    step("after_fl",   1, 2'b00, 16'h0, 6'd0, 0, 0, 0, 6'd62, 6'd5, 0, 0);
    step("run_inc",    1, 2'b00, 16'h0, 6'd0, 1, 0, 0, 6'd63, 6'd62, 0, 0);
    step("src11_hold", 1, 2'b11, 16'h0, 6'd7, 1, 0, 0, 6'd63, 6'd62, 0, 0);

    // Out-of-range ALU target traps
    step("rst_b", 0, 2'b00, 16'h0, 6'd0, 0, 0, 0, 6'd0, 6'd0, 0, 0);
    for (int i = 0; i < 5; i++)
      step($sformatf("to5b_%0d", i), 1, 2'b00, 16'h0, 6'd0, 1, 0, 0,
           6'(i + 1), 6'(i), 0, 0);
    step("alu_0040",  1, 2'b01, 16'h0040, 6'd0, 1, 0, 0, 6'd63, 6'd5, 0, 1);
    step("trap_inc",  1, 2'b00, 16'h0, 6'd0, 1, 0, 0, 6'd63, 6'd5, 0, 1);
    step("trap_jmp",  1, 2'b10, 16'h0, 6'd7, 1, 0, 0, 6'd63, 6'd5, 0, 1);
    step("trap_clr",  1, 2'b00, 16'h0, 6'd0, 1, 0, 1, 6'd63, 6'd5, 0, 0);
    step("post_clr",  1, 2'b00, 16'h0, 6'd0, 0, 0, 0, 6'd63, 6'd5, 0, 0);
    step("clr_inc",   1, 2'b00, 16'h0, 6'd0, 1, 0, 0, 6'd0, 6'd63, 0, 0);
    step("clr_in_run", 1, 2'b00, 16'h0, 6'd0, 0, 0, 1, 6'd0, 6'd63, 0, 0);

    // Narrowing boundaries, redirects chained through FLUSH
    step("alu_001f", 1, 2'b01, 16'h001F, 6'd0, 1, 0, 0, 6'd31, 6'd0, 1, 0);
    step("alu_ffe0", 1, 2'b01, 16'hFFE0, 6'd0, 1, 0, 0, 6'd32, 6'd31, 1, 0);
    step("alu_ffc0", 1, 2'b01, 16'hFFC0, 6'd0, 1, 0, 0, 6'd63, 6'd32, 0, 1);
    step("clr2",     1, 2'b00, 16'h0, 6'd0, 0, 0, 1, 6'd63, 6'd32, 0, 0);

    // Stalled jump
    step("stall0", 1, 2'b10, 16'h0, 6'd20, 1, 1, 0, 6'd63, 6'd32, 0, 0);
    step("stall1", 1, 2'b10, 16'h0, 6'd20, 1, 1, 0, 6'd63, 6'd32, 0, 0);
    step("stall2", 1, 2'b10, 16'h0, 6'd20, 1, 1, 0, 6'd63, 6'd32, 0, 0);
    step("jmp20",  1, 2'b10, 16'h0, 6'd20, 1, 0, 0, 6'd20, 6'd63, 1, 0);
    step("idle20", 1, 2'b00, 16'h0, 6'd0, 0, 0, 0, 6'd20, 6'd63, 0, 0);

    // Stall during FLUSH: state returns to RUN, PC holds
    step("jmp25",     1, 2'b10, 16'h0, 6'd25, 1, 0, 0, 6'd25, 6'd20, 1, 0);
    step("fl_stall",  1, 2'b00, 16'h0, 6'd0, 1, 1, 0, 6'd25, 6'd20, 0, 0);
    step("inc26",     1, 2'b00, 16'h0, 6'd0, 1, 0, 0, 6'd26, 6'd25, 0, 0);

    // Back-to-back jumps
    step("jmp10",  1, 2'b10, 16'h0, 6'd10, 1, 0, 0, 6'd10, 6'd26, 1, 0);
    step("jmp30",  1, 2'b10, 16'h0, 6'd30, 1, 0, 0, 6'd30, 6'd10, 1, 0);
    step("idle30", 1, 2'b00, 16'h0, 6'd0, 0, 0, 0, 6'd30, 6'd10, 0, 0);

    // Reset during FLUSH
    step("jmp40",     1, 2'b10, 16'h0, 6'd40, 1, 0, 0, 6'd40, 6'd30, 1, 0);
    step("rst_flush", 0, 2'b10, 16'h0, 6'd5, 1, 0, 0, 6'd0, 6'd0, 0, 0);
    step("post_rst1", 1, 2'b00, 16'h0, 6'd0, 0, 0, 0, 6'd0, 6'd0, 0, 0);

    // Reset during TRAP
    step("inc1",      1, 2'b00, 16'h0, 6'd0, 1, 0, 0, 6'd1, 6'd0, 0, 0);
    step("alu_0100",  1, 2'b01, 16'h0100, 6'd0, 1, 0, 0, 6'd63, 6'd1, 0, 1);
    step("rst_trap",  1'b0, 2'b00, 16'h0, 6'd0, 0, 0, 0, 6'd0, 6'd0, 0, 0);
    step("post_rst2", 1, 2'b00, 16'h0, 6'd0, 0, 0, 0, 6'd0, 6'd0, 0, 0);

    // Jump to 63 then wrap on increment
    step("jmp63",  1, 2'b10, 16'h0, 6'd63, 1, 0, 0, 6'd63, 6'd0, 1, 0);
    step("wrap",   1, 2'b00, 16'h0, 6'd0, 1, 0, 0, 6'd0, 6'd63, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    n_cmp = n_cmp + 1;
    if (exp_q.size() != 0) begin
      n_bad = n_bad + 1;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, want finish before 100000");
    $fatal(1);
  end

endmodule

// File: doc/pc_update.md
PC_UPDATE -- requirements
Module: pc_update

Interface
REQ-001 SHALL have parameter RESET_PC, default 6'd0, the PC value loaded at reset.
REQ-002 SHALL have parameter TRAP_PC, default 6'd63, the PC value loaded on a range trap.
REQ-003 SHALL have port clock  input  1  the single clock; all state changes on posedge clock.
REQ-004 SHALL have port reset_n  input  1  synchronous, active-low reset, sampled on posedge clock.
REQ-005 SHALL have port alu_result  input  16  ALU output holding a computed next-PC (branch target, operand built from sign-extended PC).
REQ-006 SHALL have port jump_addr  input  6  absolute jump target.
REQ-007 SHALL have port pc_src  input  2  next-PC select: 00 PC+1, 01 alu_result, 10 jump_addr, 11 hold.
REQ-008 SHALL have port pc_write  input  1  update enable; when 0 the PC holds.
REQ-009 SHALL have port stall  input  1  pipeline stall; overrides pc_write.
REQ-010 SHALL have port trap_clear  input  1  leaves TRAP state.
REQ-011 SHALL have port PC  output  6  current program counter (registered).
REQ-012 SHALL have port pc_prev  output  6  PC value before the last accepted update (registered).
REQ-013 SHALL have port flush  output  1  registered one-cycle pulse after any redirect (pc_src 01 or 10 accepted).
REQ-014 SHALL have port range_err  output  1  registered; high while in TRAP.

Function
REQ-015 SHALL implement states RUN, FLUSH, TRAP, encoded in a registered state variable.
REQ-016 An update SHALL be accepted on a cycle when state is RUN or FLUSH, pc_write=1, stall=0 and pc_src!=11.
REQ-017 pc_src=00 accepted: PC <= PC+1 modulo 64 (6'd63 wraps to 6'd0); no flush.
REQ-018 pc_src=01 accepted: SHALL narrow alu_result to 6 bits; legal only if alu_result[15:6] all equal alu_result[5].
REQ-019 Legal narrow: PC <= alu_result[5:0], state <= FLUSH, flush=1 next cycle.
REQ-020 Illegal narrow: PC <= TRAP_PC, state <= TRAP, range_err=1 next cycle, flush=0.
REQ-021 pc_src=10 accepted: PC <= jump_addr, state <= FLUSH, flush=1 next cycle.
REQ-022 Every accepted update SHALL set pc_prev <= old PC in the same edge.
REQ-023 FLUSH SHALL last exactly one cycle; it accepts updates as RUN; next state RUN unless that update is a redirect (stays FLUSH, flush high again) or illegal (TRAP).
REQ-024 stall=1 or pc_write=0 in FLUSH: state still returns to RUN next cycle; flush drops; PC holds.
REQ-025 TRAP: PC, pc_prev held; all updates ignored; range_err=1; flush=0.
REQ-026 TRAP with trap_clear=1: state <= RUN, range_err <= 0 next cycle; PC stays TRAP_PC.
REQ-027 trap_clear in RUN or FLUSH SHALL be ignored.
REQ-028 Latency: every output SHALL change exactly one clock after the sampling edge; no combinational input-to-output path.

Reset
REQ-029 reset_n=0 at a posedge SHALL force PC=RESET_PC, pc_prev=RESET_PC, flush=0, range_err=0, state=RUN, overriding all other inputs.
REQ-030 Reset asserted mid-FLUSH or in TRAP SHALL abandon the state with no residual flush or range_err pulse.
REQ-031 Outputs SHALL be undefined only before the first reset edge.

Verification
REQ-032 Reset, then pc_write=1, pc_src=00 for 70 cycles -> PC 0,1,...,63,0,...; pc_prev trails by one; flush never high.
REQ-033 PC=5, pc_src=01, alu_result=16'hFFFE -> PC=6'd62, pc_prev=5, flush=1 one cycle, state RUN after.
REQ-034 PC=5, pc_src=01, alu_result=16'h0040 -> PC=6'd63, range_err=1; further updates ignored; trap_clear=1 -> range_err=0 next cycle, PC still 63.
REQ-035 pc_src=10, jump_addr=6'd20 with stall=1 for 3 cycles then stall=0 -> PC holds 3 cycles, then 20, flush one cycle.
REQ-036 Back-to-back jumps to 10 then 30 -> flush high two consecutive cycles, PC 10 then 30, pc_prev=10 after second.
REQ-037 reset_n=0 in FLUSH cycle after jump to 40 -> PC=RESET_PC, flush=0 next cycle.
